// File: rtl/m_cntsched_pkg.sv
// rtl/m_cntsched_pkg.sv - shared encodings for the counter scheduler
package m_cntsched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CYC_LO = 3'd1,
    ST_CYC_HI = 3'd2,
    ST_IRT_LO = 3'd3,
    ST_IRT_HI = 3'd4,
    ST_CSR_WR = 3'd5,
    ST_CSR_RD = 3'd6
  } state_t;

  localparam logic [1:0] SEL_MCYCLE    = 2'b00;
  localparam logic [1:0] SEL_MCYCLEH   = 2'b01;
  localparam logic [1:0] SEL_MINSTRET  = 2'b10;
  localparam logic [1:0] SEL_MINSTRETH = 2'b11;

  localparam int PENDW_DEF = 9;

endpackage

// File: rtl/m_cntsched_acc.sv
// rtl/m_cntsched_acc.sv - saturating pending accumulator with whole-value drain
module m_cntsched_acc #(
  parameter int W  = 9,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          add_en,
  input  logic [AW-1:0] add,
  input  logic          drain,
  output logic [W-1:0]  value,
  output logic          ovf
);

  logic [W:0] base;
  logic [W:0] sum;

  // A drain always consumes the whole value, so only the new add-in survives it
  always_comb begin
    base = drain ? '0 : {1'b0, value};
    sum  = base + (add_en ? (W+1)'(add) : '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
      ovf   <= 1'b0;
    end else if (sum[W]) begin
      value <= '1;
      ovf   <= 1'b1;
    end else begin
      value <= sum[W-1:0];
    end
  end

endmodule

// File: rtl/m_cntsched.sv
// rtl/m_cntsched.sv - one shared 32-bit adder time-multiplexed over mcycle/minstret
module m_cntsched
  import m_cntsched_pkg::*;
#(
  parameter int DW          = 6,
  parameter int PENDW       = PENDW_DEF,
  parameter int HAS_INSTRET = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ofetch,
  input  logic [DW-1:0] delta,
  input  logic          retire,
  input  logic          csr_re,
  input  logic          csr_we,
  input  logic [1:0]    csr_sel,
  input  logic [31:0]   csr_wdat,
  output logic [31:0]   csr_rdat,
  output logic          csr_ack,
  output logic          pend_ovf,
  output logic [2:0]    dbg_state
);

  localparam bit IRT_EN = (HAS_INSTRET != 0);

  state_t state, nxt;
  logic [31:0] mcycle, mcycleh, minstret, minstreth;
  logic        cyc_c, irt_c;
  logic [PENDW-1:0] pcyc;
  logic [3:0]  pirt;
  logic        pcyc_ovf, pirt_ovf;
  logic [31:0] snap;
  logic        snap_vld, snap_irt;
  logic [31:0] add_a, add_b, add_sum, rd_val;
  logic [32:0] add_full;
  logic        add_co;

  m_cntsched_acc #(.W(PENDW), .AW(DW)) u_pcyc (
    .clk(clk), .rst_n(rst_n), .add_en(ofetch), .add(delta),
    .drain(state == ST_CYC_LO), .value(pcyc), .ovf(pcyc_ovf)
  );

  m_cntsched_acc #(.W(4), .AW(1)) u_pirt (
    .clk(clk), .rst_n(rst_n), .add_en(retire && IRT_EN), .add(1'b1),
    .drain(state == ST_IRT_LO), .value(pirt), .ovf(pirt_ovf)
  );

  assign pend_ovf  = pcyc_ovf | pirt_ovf;
  assign dbg_state = state;

  always_comb begin
    add_a = '0;
    add_b = '0;
    case (state)
      ST_CYC_LO: begin add_a = mcycle;    add_b = 32'(pcyc); end
      ST_CYC_HI: begin add_a = mcycleh;   add_b = 32'd1;     end
      ST_IRT_LO: begin add_a = minstret;  add_b = 32'(pirt); end
      ST_IRT_HI: begin add_a = minstreth; add_b = 32'd1;     end
      default: ;
    endcase
    add_full = {1'b0, add_a} + {1'b0, add_b};
    add_sum  = add_full[31:0];
    add_co   = add_full[32];
  end

  // High words come from the snapshot taken by the paired low-word read
  always_comb begin
    rd_val = '0;
    case (csr_sel)
      SEL_MCYCLE:   rd_val = mcycle;
      SEL_MCYCLEH:  rd_val = (snap_vld && !snap_irt) ? snap : mcycleh;
      SEL_MINSTRET: rd_val = IRT_EN ? minstret : '0;
      default:      rd_val = !IRT_EN ? '0 : (snap_vld && snap_irt) ? snap : minstreth;
    endcase
  end

  // Reads reach the bottom of the priority chain only once both counters are settled
  always_comb begin
    nxt = ST_IDLE;
    case (state)
      ST_IDLE: begin
        if (cyc_c)                          nxt = ST_CYC_HI;
        else if (irt_c)                     nxt = ST_IRT_HI;
        else if (csr_we)                    nxt = ST_CSR_WR;
        else if (pcyc != '0)                nxt = ST_CYC_LO;
        else if (IRT_EN && (pirt != '0))    nxt = ST_IRT_LO;
        else if (csr_re)                    nxt = ST_CSR_RD;
      end
      ST_CYC_LO: nxt = add_co ? ST_CYC_HI : ST_IDLE;
      ST_IRT_LO: nxt = add_co ? ST_IRT_HI : ST_IDLE;
      default:   nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      mcycle    <= '0;
      mcycleh   <= '0;
      minstret  <= '0;
      minstreth <= '0;
      cyc_c     <= 1'b0;
      irt_c     <= 1'b0;
      snap      <= '0;
      snap_vld  <= 1'b0;
      snap_irt  <= 1'b0;
      csr_ack   <= 1'b0;
      csr_rdat  <= '0;
    end else begin
      state   <= nxt;
      csr_ack <= (nxt == ST_CSR_WR) || (nxt == ST_CSR_RD);
      case (state)
        ST_CYC_LO: begin mcycle  <= add_sum; cyc_c <= add_co; end
        ST_CYC_HI: begin mcycleh <= add_sum; cyc_c <= 1'b0;   end
        ST_IRT_LO: if (IRT_EN) begin minstret  <= add_sum; irt_c <= add_co; end
        ST_IRT_HI: if (IRT_EN) begin minstreth <= add_sum; irt_c <= 1'b0;   end
        ST_CSR_WR: begin
          snap_vld <= 1'b0;
          case (csr_sel)
            SEL_MCYCLE:   begin mcycle <= csr_wdat; cyc_c <= 1'b0; end
            SEL_MCYCLEH:  mcycleh <= csr_wdat;
            SEL_MINSTRET: if (IRT_EN) begin minstret <= csr_wdat; irt_c <= 1'b0; end
            default:      if (IRT_EN) minstreth <= csr_wdat;
          endcase
        end
        default: ;
      endcase
      if (nxt == ST_CSR_RD) begin
        csr_rdat <= rd_val;
        case (csr_sel)
          SEL_MCYCLE:   begin snap <= mcycleh;   snap_vld <= 1'b1;   snap_irt <= 1'b0; end
          SEL_MINSTRET: begin snap <= minstreth; snap_vld <= IRT_EN; snap_irt <= 1'b1; end
          SEL_MCYCLEH:  if (snap_irt)  snap_vld <= 1'b0;
          default:      if (!snap_irt) snap_vld <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_m_cntsched.sv
// tb/tb_m_cntsched.sv - directed and randomized checks of m_cntsched against a 64-bit counter model
module tb_m_cntsched;
  import m_cntsched_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ofetch = 1'b0;
  logic [5:0]  delta = '0;
  logic        retire = 1'b0;
  logic        csr_re = 1'b0;
  logic        csr_we = 1'b0;
  logic [1:0]  csr_sel = '0;
  logic [31:0] csr_wdat = '0;
  logic [31:0] csr_rdat;
  logic        csr_ack;
  logic        pend_ovf;
  logic [2:0]  dbg_state;

  int n_chk = 0;
  int n_pass = 0;

  m_cntsched dut (
    .clk(clk), .rst_n(rst_n), .ofetch(ofetch), .delta(delta), .retire(retire),
    .csr_re(csr_re), .csr_we(csr_we), .csr_sel(csr_sel), .csr_wdat(csr_wdat),
    .csr_rdat(csr_rdat), .csr_ack(csr_ack), .pend_ovf(pend_ovf), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic csr_write(input logic [1:0] sel, input logic [31:0] d);
    int n;
    n = 0;
    csr_we = 1'b1; csr_sel = sel; csr_wdat = d;
    do begin @(negedge clk); n++; end while (!csr_ack && n < 100);
    chk("wr_ack", csr_ack, 1);
    csr_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic csr_read(input logic [1:0] sel, output logic [31:0] d);
    int n;
    n = 0;
    csr_re = 1'b1; csr_sel = sel;
    do begin @(negedge clk); n++; end while (!csr_ack && n < 200);
    chk("rd_ack", csr_ack, 1);
    d = csr_rdat;
    csr_re = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] st, input string tag);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (dbg_state != st && n < 50);
    chk(tag, dbg_state, st);
  endtask

  logic [31:0] d;
  logic [2:0]  seq[$];
  logic [63:0] m_cyc, m_irt;
  logic [31:0] wl, wh;
  int          n;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ack", csr_ack, 0);
    chk("rst_rdat", csr_rdat, 0);
    chk("rst_ovf", pend_ovf, 0);
    chk("rst_state", dbg_state, ST_IDLE);
    rst_n = 1'b1;
    @(negedge clk);

    // three fetches of 5 cycles, back to back
    ofetch = 1'b1; delta = 6'd5;
    repeat (3) @(negedge clk);
    ofetch = 1'b0;
    csr_read(SEL_MCYCLE, d);  chk("acc15_lo", d, 15);
    csr_read(SEL_MCYCLEH, d); chk("acc15_hi", d, 0);
    chk("acc15_ovf", pend_ovf, 0);

    // deferred carry and a read racing it
    csr_write(SEL_MCYCLE, 32'hFFFF_FFFE);
    ofetch = 1'b1; delta = 6'd3;
    @(negedge clk);
    ofetch = 1'b0;
    wait_state(ST_CYC_LO, "carry_cyc_lo");
    csr_re = 1'b1; csr_sel = SEL_MCYCLE;
    @(negedge clk);
    chk("carry_cyc_hi", dbg_state, ST_CYC_HI);
    chk("carry_no_ack", csr_ack, 0);
    n = 1;
    while (!csr_ack && n < 50) begin @(negedge clk); n++; end
    csr_re = 1'b0;
    chk("carry_rd_lat", n, 3);
    chk("carry_rd_lo", csr_rdat, 1);
    csr_read(SEL_MCYCLEH, d); chk("carry_rd_hi", d, 1);

    // cycle drain, then instret drain, then the read
    ofetch = 1'b1; delta = 6'd10; retire = 1'b1;
    @(negedge clk);
    ofetch = 1'b0; retire = 1'b0;
    csr_re = 1'b1; csr_sel = SEL_MINSTRET;
    n = 0;
    do begin
      @(negedge clk); n++;
      if (dbg_state != ST_IDLE) seq.push_back(dbg_state);
    end while (!csr_ack && n < 50);
    csr_re = 1'b0;
    chk("order_len", seq.size(), 3);
    if (seq.size() == 3) begin
      chk("order_0", seq[0], ST_CYC_LO);
      chk("order_1", seq[1], ST_IRT_LO);
      chk("order_2", seq[2], ST_CSR_RD);
    end
    chk("order_rdat", csr_rdat, 1);
    csr_read(SEL_MCYCLE, d); chk("order_mcycle", d, 11);

    // snapshot coherence across a carry landing between the two halves
    csr_write(SEL_MCYCLE, 32'hFFFF_FFF0);
    csr_write(SEL_MCYCLEH, 32'd7);
    csr_read(SEL_MCYCLE, d); chk("snap_lo", d, 32'hFFFF_FFF0);
    ofetch = 1'b1; delta = 6'd32;
    @(negedge clk);
    ofetch = 1'b0;
    csr_read(SEL_MCYCLEH, d);  chk("snap_hi_old", d, 7);
    csr_read(SEL_MINSTRET, d); chk("snap_irt", d, 1);
    csr_read(SEL_MCYCLEH, d);  chk("snap_hi_new", d, 8);
    csr_read(SEL_MCYCLE, d);   chk("snap_lo_new", d, 32'h10);

    // held write starves the cycle drain until pcyc saturates
    csr_we = 1'b1; csr_sel = SEL_MCYCLE; csr_wdat = 32'h100;
    ofetch = 1'b1; delta = 6'd63;
    repeat (20) @(negedge clk);
    csr_we = 1'b0; ofetch = 1'b0;
    chk("sat_ovf", pend_ovf, 1);
    repeat (10) @(negedge clk);
    chk("sat_ovf_sticky", pend_ovf, 1);
    csr_read(SEL_MCYCLE, d);  chk("sat_mcycle", d, 32'h100 + 511);
    csr_read(SEL_MCYCLEH, d); chk("sat_mcycleh", d, 8);

    // asynchronous reset in the middle of a carry
    csr_write(SEL_MCYCLE, 32'hFFFF_FFFF);
    ofetch = 1'b1; delta = 6'd1;
    @(negedge clk);
    ofetch = 1'b0;
    wait_state(ST_CYC_HI, "rst_mid_hi");
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_state", dbg_state, ST_IDLE);
    chk("rst_mid_ack", csr_ack, 0);
    chk("rst_mid_ovf", pend_ovf, 0);
    chk("rst_mid_rdat", csr_rdat, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    csr_read(SEL_MCYCLE, d);    chk("rst_mcycle", d, 0);
    csr_read(SEL_MCYCLEH, d);   chk("rst_mcycleh", d, 0);
    csr_read(SEL_MINSTRET, d);  chk("rst_minstret", d, 0);
    csr_read(SEL_MINSTRETH, d); chk("rst_minstreth", d, 0);

    // randomized bursts against plain 64-bit totals
    m_cyc = '0; m_irt = '0;
    for (int r = 0; r < 6; r++) begin
      wl = 32'hFFFF_FFFF - $urandom_range(0, 400);
      wh = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      csr_write(SEL_MCYCLE, wl);
      csr_write(SEL_MCYCLEH, wh);
      m_cyc = {wh, wl};
      wl = 32'hFFFF_FFFF - $urandom_range(0, 40);
      wh = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      csr_write(SEL_MINSTRET, wl);
      csr_write(SEL_MINSTRETH, wh);
      m_irt = {wh, wl};
      for (int c = 0; c < 60; c++) begin
        ofetch = ($urandom_range(0, 2) == 0);
        delta  = 6'($urandom_range(1, 63));
        retire = ($urandom_range(0, 1) == 1);
        if (ofetch) m_cyc = m_cyc + 64'(delta);
        if (retire) m_irt = m_irt + 64'd1;
        @(negedge clk);
      end
      ofetch = 1'b0; retire = 1'b0;
      repeat (12) @(negedge clk);
      csr_read(SEL_MCYCLE, d);    chk("rnd_cyc_lo", d, m_cyc[31:0]);
      csr_read(SEL_MCYCLEH, d);   chk("rnd_cyc_hi", d, m_cyc[63:32]);
      csr_read(SEL_MINSTRET, d);  chk("rnd_irt_lo", d, m_irt[31:0]);
      csr_read(SEL_MINSTRETH, d); chk("rnd_irt_hi", d, m_irt[63:32]);
      chk("rnd_ovf", pend_ovf, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
